// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//
// Memory-access pipeline stage that sits directly behind the control unit.
// It turns a decoded load/store (mem_read / mem_write) into exactly one
// start/done transaction on the CPU memory bus. It stalls the upstream
// pipeline while that transaction is outstanding and returns load data for
// the dreg write-back. A bounded wait aborts the access if the slave never
// answers, so a dead slave cannot hang the CPU.
//
// Parameters
//   ADDR_W   bus address width
//   DATA_W   data word width
//   TIMEOUT  max WAIT cycles without bus_done before abort (>= 1)
//   CNT_W    timeout counter width, 2**CNT_W must exceed TIMEOUT
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   valid               an instruction occupies this stage
//   mem_read/mem_write  decoded strobes (both high = illegal op)
//   addr, wdata         effective address and store data
//   stall               combinational hold request to upstream registers
//   rdata, rdata_valid  load result plus its one-cycle valid pulse
//   bus_start           one-cycle request pulse to the slave
//   bus_we/addr/data    latched request, stable from start until done
//   bus_q, bus_done     slave read data and completion pulse
//   bus_err             one-cycle pulse when the access timed out
//   op_illegal          one-cycle pulse for read+write issued together
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int ADDR_W  = 27,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              bus_start,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_data,
    input  logic [DATA_W-1:0] bus_q,
    input  logic              bus_done,
    output logic              bus_err,
    output logic              op_illegal
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Request as presented to the bus; captured once at start and held
    // untouched until the next start.
    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } bus_req_t;

    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

    state_t           state;
    bus_req_t         req_q;
    logic [CNT_W-1:0] cnt;
    logic             req;
    logic             illegal;

    // Exactly one strobe makes a real access; both strobes together is
    // flagged instead of guessing which one was meant.
    assign req     = valid & (mem_read ^ mem_write);
    assign illegal = valid & mem_read & mem_write;

    assign bus_we   = req_q.we;
    assign bus_addr = req_q.addr;
    assign bus_data = req_q.data;

    // Stall starts in the request cycle itself, before the FSM has moved,
    // so upstream holds the instruction for the whole access. Gating with
    // reset lets stall fall as soon as reset rises, even if valid is still
    // held high.
    assign stall = ~reset & (((state == ST_IDLE) & req) | (state == ST_WAIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            req_q       <= '0;
            cnt         <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            bus_start   <= 1'b0;
            bus_err     <= 1'b0;
            op_illegal  <= 1'b0;
        end else begin
            // All pulse outputs default low; each is raised for one cycle.
            bus_start   <= 1'b0;
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
            op_illegal  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (req) begin
                        req_q.we   <= mem_write;
                        req_q.addr <= addr;
                        req_q.data <= wdata;
                        bus_start  <= 1'b1;
                        cnt        <= '0;
                        state      <= ST_WAIT;
                    end else if (illegal) begin
                        op_illegal <= 1'b1;
                    end
                end

                ST_WAIT: begin
                    // Completion is checked before the timeout. A done
                    // that arrives on the last allowed cycle still succeeds.
                    if (bus_done) begin
                        if (!req_q.we) rdata <= bus_q;
                        rdata_valid <= 1'b1;
                        state       <= ST_DONE;
                    end else if (cnt == TMO) begin
                        rdata       <= '0;
                        bus_err     <= 1'b1;
                        rdata_valid <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                // The instruction leaves the stage during DONE (stall low).
                // The following IDLE therefore sees the next instruction,
                // and this one is never issued twice.
                ST_DONE: state <= ST_IDLE;

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    localparam int AW = 27;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          valid, mem_read, mem_write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          stall;
    logic [DW-1:0] rdata;
    logic          rdata_valid, bus_start, bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_data, bus_q;
    logic          bus_done, bus_err, op_illegal;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;

    mem_access_stage #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .valid(valid), .mem_read(mem_read),
        .mem_write(mem_write), .addr(addr), .wdata(wdata), .stall(stall),
        .rdata(rdata), .rdata_valid(rdata_valid), .bus_start(bus_start),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_data(bus_data),
        .bus_q(bus_q), .bus_done(bus_done), .bus_err(bus_err),
        .op_illegal(op_illegal)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one access and play the slave: bus_done is pulsed dly cycles
    // after the observed bus_start cycle (dly < 0: slave never answers).
    // The instruction is held until its rdata_valid cycle, then removed.
    // The wait is bounded to 40 cycles; lat stays -1 if it expires.
    task automatic do_txn(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input int dly, input logic [DW-1:0] q,
                          output int n_stall, output int n_start, output int n_rv,
                          output int n_err, output int lat, output int start_cyc,
                          output logic [DW-1:0] rd_val, output logic we_s,
                          output logic [AW-1:0] addr_s, output logic stable);
        int s;
        logic done_seen;
        logic [DW-1:0] d_s;
        s = -1; done_seen = 1'b0; d_s = '0;
        n_stall = 0; n_start = 0; n_rv = 0; n_err = 0; lat = -1; start_cyc = -1;
        rd_val = '0; we_s = 1'b0; addr_s = '0; stable = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_start === 1'b1) begin
                n_start++;
                if (s < 0) begin
                    s = i; start_cyc = cyc;
                    we_s = bus_we; addr_s = bus_addr; d_s = bus_data;
                end
            end
            valid = 1'b1; mem_read = rd; mem_write = wr; addr = a; wdata = wd;
            bus_done = (s >= 0 && dly >= 0 && i == s + dly);
            bus_q    = bus_done ? q : 32'hBAD0BAD0;
            #1;
            if (stall === 1'b1) n_stall++;
            if (bus_err === 1'b1) n_err++;
            if (s >= 0 && !done_seen &&
                (bus_we !== we_s || bus_addr !== addr_s || bus_data !== d_s)) stable = 1'b0;
            if (bus_done) done_seen = 1'b1;
            if (rdata_valid === 1'b1) begin
                n_rv++; rd_val = rdata; lat = i;
                break;
            end
        end
        valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; bus_done = 1'b0;
    endtask

    int ns, nst, nrv, ner, lat, sc, sc1;
    logic [DW-1:0] rv;
    logic we_s, stab;
    logic [AW-1:0] a_s;

    initial begin
        reset = 1'b1; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        addr = '0; wdata = '0; bus_q = '0; bus_done = 1'b0;

        // Reset values
        #12;
        chk("rst_stall", stall, 0);
        chk("rst_pulses", {rdata_valid, bus_start, bus_err, op_illegal, bus_we}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_data", bus_data, 0);
        @(negedge clk); reset = 1'b0;

        // Strobe without valid is ignored
        @(negedge clk); valid = 1'b0; mem_read = 1'b1; #1;
        chk("novalid_stall", stall, 0);
        @(negedge clk);
        chk("novalid_start", bus_start, 0);
        mem_read = 1'b0;

        // Read, slave done 3 cycles after start
        do_txn(1, 0, 27'h0000123, 32'h0, 3, 32'hDEADBEEF, ns, nst, nrv, ner, lat, sc, rv, we_s, a_s, stab);
        chk("rd_starts", nst, 1);
        chk("rd_we", we_s, 0);
        chk("rd_addr", a_s, 27'h0000123);
        chk("rd_stall_cycles", ns, 5);
        chk("rd_latency", lat, 5);
        chk("rd_data", rv, 32'hDEADBEEF);
        chk("rd_err", ner, 0);
        chk("rd_stable", stab, 1);
        @(negedge clk);
        chk("rd_rv_one_cycle", rdata_valid, 0);
        chk("rd_rdata_hold", rdata, 32'hDEADBEEF);

        // Write, slave done 1 cycle after start
        do_txn(0, 1, 27'h7FFFFFF, 32'h12345678, 1, 32'hCAFEF00D, ns, nst, nrv, ner, lat, sc, rv, we_s, a_s, stab);
        chk("wr_starts", nst, 1);
        chk("wr_we", we_s, 1);
        chk("wr_addr", a_s, 27'h7FFFFFF);
        chk("wr_stable", stab, 1);
        chk("wr_stall_cycles", ns, 3);
        chk("wr_rv", nrv, 1);
        chk("wr_rdata_unchanged", rv, 32'hDEADBEEF);
        chk("wr_bus_data", bus_data, 32'h12345678);

        // Back-to-back reads, done one cycle after each start
        do_txn(1, 0, 27'h0000010, 32'h0, 1, 32'h11111111, ns, nst, nrv, ner, lat, sc1, rv, we_s, a_s, stab);
        chk("b2b1_starts", nst, 1);
        chk("b2b1_data", rv, 32'h11111111);
        do_txn(1, 0, 27'h0000020, 32'h0, 1, 32'h22222222, ns, nst, nrv, ner, lat, sc, rv, we_s, a_s, stab);
        chk("b2b2_starts", nst, 1);
        chk("b2b2_addr", a_s, 27'h0000020);
        chk("b2b2_data", rv, 32'h22222222);
        chk("b2b_start_gap", sc - sc1, 4);
        chk("b2b2_stall_cycles", ns, 3);

        // Timeout: slave never answers (TIMEOUT = 4)
        do_txn(1, 0, 27'h0ABCDEF, 32'h0, -1, 32'h0, ns, nst, nrv, ner, lat, sc, rv, we_s, a_s, stab);
        chk("tmo_stall_cycles", ns, 6);
        chk("tmo_latency", lat, 6);
        chk("tmo_err", ner, 1);
        chk("tmo_rdata", rv, 32'h0);
        @(negedge clk);
        chk("tmo_err_one_cycle", bus_err, 0);
        @(negedge clk);
        @(negedge clk); bus_done = 1'b1; bus_q = 32'hFFFFFFFF; #1;
        chk("late_done_stall", stall, 0);
        @(negedge clk); bus_done = 1'b0;
        chk("late_done_pulses", {rdata_valid, bus_start, bus_err}, 0);
        chk("late_done_rdata", rdata, 0);

        // Illegal op: both strobes high
        @(negedge clk); valid = 1'b1; mem_read = 1'b1; mem_write = 1'b1; #1;
        chk("ill_stall", stall, 0);
        @(negedge clk);
        chk("ill_pulse", op_illegal, 1);
        chk("ill_no_start", bus_start, 0);
        valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        chk("ill_pulse_one_cycle", op_illegal, 0);
        chk("ill_no_start2", bus_start, 0);

        // Reset in WAIT, stale done afterwards
        @(negedge clk); valid = 1'b1; mem_read = 1'b1; addr = 27'h0000055;
        @(negedge clk);
        chk("rstw_start", bus_start, 1);
        @(negedge clk); #1;
        chk("rstw_stall_before", stall, 1);
        reset = 1'b1; #1;
        chk("rstw_stall_drop", stall, 0);
        chk("rstw_bus_addr", bus_addr, 0);
        valid = 1'b0; mem_read = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(negedge clk); bus_done = 1'b1; bus_q = 32'h77777777; #1;
        chk("rstw_stall_after", stall, 0);
        @(negedge clk); bus_done = 1'b0;
        chk("rstw_no_rv", {rdata_valid, bus_start, bus_err}, 0);
        chk("rstw_rdata", rdata, 0);

        // Minimum-latency read after reset: done in the start cycle
        do_txn(1, 0, 27'h0000042, 32'h0, 0, 32'hA5A5A5A5, ns, nst, nrv, ner, lat, sc, rv, we_s, a_s, stab);
        chk("min_stall_cycles", ns, 2);
        chk("min_latency", lat, 2);
        chk("min_data", rv, 32'hA5A5A5A5);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage directly downstream of the control unit. It consumes the decoded mem_read/mem_write strobes plus the address and data operands.
- It runs a single-transaction start/done handshake against the CPU memory bus, stalls the pipeline while the access is outstanding, and delivers read data for the dreg write-back.
- A bounded wait timeout keeps a dead slave from hanging the CPU.

Parameters:
- ADDR_W, 27, bus address width.
- DATA_W, 32, data word width.
- TIMEOUT, 1023, max cycles waiting for bus_done before abort; must be ≥1.
- CNT_W, 10, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid  in  1  an instruction occupies this stage this cycle.
- mem_read  in  1  decoded read strobe from control unit.
- mem_write  in  1  decoded write strobe from control unit.
- addr  in  ADDR_W  effective address.
- wdata  in  DATA_W  store data.
- stall  out  1  hold upstream pipeline registers.
- rdata  out  DATA_W  read result for write-back.
- rdata_valid  out  1  one-cycle pulse, rdata usable this cycle.
- bus_start  out  1  one-cycle transaction request pulse.
- bus_we  out  1  1 = write, 0 = read; stable from start to done.
- bus_addr  out  ADDR_W  latched address, stable from start to done.
- bus_data  out  DATA_W  latched write data, stable from start to done.
- bus_q  in  DATA_W  read data, valid when bus_done = 1.
- bus_done  in  1  slave completion pulse.
- bus_err  out  1  one-cycle pulse on timeout abort.
- op_illegal  out  1  one-cycle pulse: valid with mem_read and mem_write both high.

Behaviour:
- Reset values: state = IDLE; stall, rdata_valid, bus_start, bus_we, bus_err, op_illegal = 0; rdata, bus_addr, bus_data = 0; counter = 0.
- "req" = valid & (mem_read ^ mem_write).
- States: IDLE, WAIT, DONE.
- IDLE:
  - If req, next edge: latch addr/wdata/bus_we(=mem_write); bus_start = 1 for exactly that following cycle; counter = 0; go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - bus_start is low after its first cycle in WAIT.
  - If bus_done: if read, rdata <= bus_q; go to DONE.
  - Else if counter == TIMEOUT: rdata <= 0; bus_err pulses in DONE; go to DONE.
  - Else counter += 1.
- DONE:
  - rdata_valid = 1 for one cycle; stall = 0; unconditionally go to IDLE next edge.
  - The instruction advances during this cycle and is not re-issued.
  - Writes also pass through DONE; rdata_valid pulses, but the control unit does not assert dreg_we for writes.
- stall (combinational) = (state == IDLE & req) | (state == WAIT). Minimum stall is 2 cycles (IDLE + start cycle); latency from req to rdata_valid is 2 + slave cycles.
- rdata holds its last value outside DONE.
- Illegal op (both strobes high, valid): no bus access, no stall; op_illegal pulses one cycle registered (next edge).
- valid = 0: strobes ignored.
- bus_done while in IDLE or DONE: ignored (stale completion after reset or timeout).
- bus_done on the same edge the counter reaches TIMEOUT: done wins, no bus_err.
- Reset mid-transaction: immediate return to reset values, stall drops asynchronously; any later bus_done is ignored.
- Only one outstanding transaction at a time; no address alignment or width checking.

Test Plan:
- Read, slave done 3 cycles after start, addr = 0x0000123, bus_q = 0xDEADBEEF -> one bus_start pulse with bus_we = 0 and bus_addr = 0x0000123; stall high for 5 cycles; rdata = 0xDEADBEEF with rdata_valid in the next cycle.
- Write addr = 0x7FFFFFF, wdata = 0x12345678, done 1 cycle after start -> bus_we = 1; bus_data stable until done; stall 3 cycles; no rdata change.
- Back-to-back read then read, done immediately after start -> two bus_start pulses separated by DONE + IDLE; each transaction issued exactly once.
- TIMEOUT = 4, slave never responds -> DONE after 5 WAIT cycles; bus_err pulse; rdata = 0; late bus_done 3 cycles later ignored.
- valid = 1, mem_read = mem_write = 1 -> op_illegal pulse; no bus_start; stall stays 0.
- Reset asserted in WAIT, then bus_done pulse after release -> stall drops the same cycle as reset; state IDLE; no rdata_valid.
